pb_debounce_ctrl: RTL
=====================

# pb_debounce_ctrl

Conditions the raw, active-low push-button input PB_SW into clean, clock-synchronous control events for the LED logic inside Top. It sits directly between the PB_SW pad and the LED pattern logic. It synchronises the input, debounces it with a restartable counter, and emits a debounced level plus single-cycle press, release and long-press pulses. It also keeps a wrapping count of debounced presses.

## Interface
- DEBOUNCE_CYCLES, 16'd50000: consecutive stable cycles required to accept a level change; legal range 2..65535.
- LONG_CYCLES, 32'd50000000: cycles held after the debounced press before PB_LONG fires; minimum 1.
- CNT_WIDTH, 8: width of PRESS_CNT.
- CLK  input  1  fabric clock; all logic is on the rising edge.
- RST  input  1  reset, synchronous and active-high.
- PB_SW  input  1  raw push-button, asynchronous; 0 = pressed.
- PB_LEVEL  output  1  debounced level; 1 = pressed.
- PB_PRESS  output  1  one-cycle pulse when a press is accepted.
- PB_RELEASE  output  1  one-cycle pulse when a release is accepted.
- PB_LONG  output  1  one-cycle pulse, at most once per press.
- PRESS_CNT  output  CNT_WIDTH  number of accepted presses, modulo 2^CNT_WIDTH.

## Operation
- Synchroniser: two flops on PB_SW, both reset to 1 (released). SW_S is the output of the second flop. Its inversion is the internal pressed sample P.
- FSM has four states; reset state is IDLE.
  - IDLE: stable released. P=1 → PRESS_WAIT, and the debounce counter loads 1.
  - PRESS_WAIT: P=1 and counter < DEBOUNCE_CYCLES → increment the counter. P=1 and counter = DEBOUNCE_CYCLES → PRESSED; pulse PB_PRESS; increment PRESS_CNT; clear the long counter. P=0 → IDLE, counter cleared (bounce restarts the qualification).
  - PRESSED: stable pressed; PB_LEVEL=1. The long counter increments while below LONG_CYCLES. On reaching LONG_CYCLES it pulses PB_LONG once and then saturates. P=0 → RELEASE_WAIT, counter loads 1.
  - RELEASE_WAIT: the mirror of PRESS_WAIT on P=0. Completion → IDLE and pulses PB_RELEASE. P=1 before completion → back to PRESSED with the long counter preserved, not cleared. PB_LEVEL stays 1 throughout this state.
- The debounce counter is 16 bits. The long counter is 32 bits. Neither wraps.
- PRESS_CNT wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- PB_PRESS, PB_RELEASE and PB_LONG are never high in the same cycle.
  - A long-press completion and a release start in the same cycle: PB_LONG still fires, because the counter reached its limit while the state was PRESSED.

## Timing
- Reset values: PB_LEVEL=0, PB_PRESS=0, PB_RELEASE=0, PB_LONG=0, PRESS_CNT=0, FSM=IDLE, counters=0, synchroniser=1.
- RST is sampled on the CLK edge. Asserting it mid-operation aborts any wait or long count.
  - The first cycle after RST deasserts shows reset values.
  - A button held through reset is re-qualified as a fresh press, with full synchroniser and debounce latency.
- Press latency: PB_SW is low and stable from rising edge k. PB_PRESS is high in the cycle following edge k+DEBOUNCE_CYCLES+2. PB_LEVEL rises on the same edge.
- Release latency is identical: PB_RELEASE pulses and PB_LEVEL falls DEBOUNCE_CYCLES+2 edges after PB_SW returns high.
- Long latency: PB_LONG pulses exactly LONG_CYCLES cycles after the PB_PRESS cycle, provided the state never reached IDLE in between.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Use DEBOUNCE_CYCLES=8, LONG_CYCLES=20, CNT_WIDTH=4 unless stated otherwise.
- Clean press: PB_SW goes 1→0 at edge 10 and is held 15 cycles → PB_PRESS is a single pulse after edge 20, PB_LEVEL=1, PRESS_CNT=1, no PB_LONG.
- Bounce reject: PB_SW toggles low for 5 cycles, high for 1, then repeats 3 times → PB_PRESS never fires, PB_LEVEL stays 0, PRESS_CNT=0.
- Bounce then settle: after the bounce pattern above, hold PB_SW low → PB_PRESS fires 10 edges after the last 1→0 transition.
- Long press: hold low for 60 cycles, then release → PB_LONG fires once, 20 cycles after PB_PRESS. PB_RELEASE fires 10 edges after PB_SW rises; PB_LEVEL=0 afterwards.
- Release glitch: while pressed at long count 12, drive PB_SW high for 3 cycles → no PB_RELEASE; PB_LONG still fires 20 cycles after PB_PRESS.
- Wrap and reset: 17 clean presses → PRESS_CNT reads 1. Assert RST for 1 cycle during PRESS_WAIT → all outputs return to reset values; a held button yields PB_PRESS at DEBOUNCE_CYCLES+2 edges after RST deasserts.

Source files
------------

// File: rtl/pb_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// pb_debounce_ctrl : synchronises and debounces an active-low push-button,
//                    emitting level, press/release/long pulses and a press count
// Rev 1.0
// ============================================================================
module pb_debounce_ctrl #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [31:0] LONG_CYCLES     = 32'd50000000,
   parameter int          CNT_WIDTH       = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 PB_SW,
   output logic                 PB_LEVEL,
   output logic                 PB_PRESS,
   output logic                 PB_RELEASE,
   output logic                 PB_LONG,
   output logic [CNT_WIDTH-1:0] PRESS_CNT
);

   localparam logic [1:0] S_IDLE         = 2'd0;
   localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] S_PRESSED      = 2'd2;
   localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

   logic [1:0]           state_q, state_d;
   logic                 sync1_q, sync1_d;
   logic                 sw_s_q, sw_s_d;
   logic [15:0]          db_cnt_q, db_cnt_d;
   logic [31:0]          long_cnt_q, long_cnt_d;
   logic [CNT_WIDTH-1:0] press_cnt_q, press_cnt_d;
   logic                 level_q, level_d;
   logic                 press_q, press_d;
   logic                 release_q, release_d;
   logic                 long_q, long_d;

   logic pressed;
   logic db_done;
   logic long_run;

   assign pressed  = ~sw_s_q;
   assign db_done  = (db_cnt_q >= DEBOUNCE_CYCLES);
   assign long_run = (long_cnt_q < LONG_CYCLES);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         sync1_q     <= 1'b1;
         sw_s_q      <= 1'b1;
         db_cnt_q    <= '0;
         long_cnt_q  <= '0;
         press_cnt_q <= '0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sw_s_q      <= sw_s_d;
         db_cnt_q    <= db_cnt_d;
         long_cnt_q  <= long_cnt_d;
         press_cnt_q <= press_cnt_d;
         level_q     <= level_d;
         press_q     <= press_d;
         release_q   <= release_d;
         long_q      <= long_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:         if (pressed) state_d = S_PRESS_WAIT;
         S_PRESS_WAIT: begin
            if (!pressed)     state_d = S_IDLE;
            else if (db_done) state_d = S_PRESSED;
         end
         S_PRESSED:      if (!pressed) state_d = S_RELEASE_WAIT;
         S_RELEASE_WAIT: begin
            if (pressed)      state_d = S_PRESSED;
            else if (db_done) state_d = S_IDLE;
         end
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sync1_d     = PB_SW;
      sw_s_d      = sync1_q;
      db_cnt_d    = db_cnt_q;
      long_cnt_d  = long_cnt_q;
      press_cnt_d = press_cnt_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      level_d     = (state_d == S_PRESSED) || (state_d == S_RELEASE_WAIT);

      case (state_q)
         S_IDLE: db_cnt_d = pressed ? 16'd1 : 16'd0;
         S_PRESS_WAIT: begin
            if (!pressed) begin
               db_cnt_d = '0;
            end else if (db_done) begin
               db_cnt_d    = '0;
               long_cnt_d  = '0;
               press_d     = 1'b1;
               press_cnt_d = press_cnt_q + CNT_WIDTH'(1);
            end else begin
               db_cnt_d = db_cnt_q + 16'd1;
            end
         end
         S_PRESSED: begin
            db_cnt_d = pressed ? 16'd0 : 16'd1;
            if (long_run) begin
               long_cnt_d = long_cnt_q + 32'd1;
               long_d     = (long_cnt_q == LONG_CYCLES - 32'd1);
            end
         end
         S_RELEASE_WAIT: begin
            if (pressed)      db_cnt_d = '0;
            else if (db_done) db_cnt_d = '0;
            else              db_cnt_d = db_cnt_q + 16'd1;
            if (!pressed && db_done) begin
               release_d = 1'b1;
            // A glitch back to pressed keeps the hold timer running, so the
            // long-press timing is measured from the accepted press only.
            end else if (long_run) begin
               long_cnt_d = long_cnt_q + 32'd1;
               long_d     = (long_cnt_q == LONG_CYCLES - 32'd1);
            end
         end
         default: db_cnt_d = '0;
      endcase
   end

   assign PB_LEVEL   = level_q;
   assign PB_PRESS   = press_q;
   assign PB_RELEASE = release_q;
   assign PB_LONG    = long_q;
   assign PRESS_CNT  = press_cnt_q;

endmodule
`default_nettype wire
